// File: rtl/mc_pkg.sv
// mc_pkg - shared definitions for the multi-cycle MIPS controller.
//
// Holds the FSM state encodings, the opcode/func constants of the supported
// instructions, and the select encodings that the datapath multiplexers
// decode. The select encodings match the single-cycle decoder, so existing
// datapath muxes can import this package unchanged.
//
// No ports (package).

package mc_pkg;

    // FSM state encodings, also visible on the controller's state output
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXE    = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] OP_BNEZALC = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FUNC_ADD = 6'b100000;
    localparam logic [5:0] FUNC_SUB = 6'b100010;
    localparam logic [5:0] FUNC_JR  = 6'b001000;

    // Register destination select
    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    // ALU B-operand select
    localparam logic [1:0] ALUSRC_REG = 2'b00;
    localparam logic [1:0] ALUSRC_IMM = 2'b01;

    // ALU operation
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;

    // Writeback source select
    localparam logic [1:0] MEMTOREG_ALU = 2'b00;
    localparam logic [1:0] MEMTOREG_DM  = 2'b01;
    localparam logic [1:0] MEMTOREG_PC  = 2'b10;
    localparam logic [1:0] MEMTOREG_LUI = 2'b11;

    // Next-PC select
    localparam logic [1:0] NPC_PC4 = 2'b00;
    localparam logic [1:0] NPC_J   = 2'b01;
    localparam logic [1:0] NPC_BR  = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    // Comparator mode
    localparam logic [2:0] CMP_EQ  = 3'b000;
    localparam logic [2:0] CMP_NEZ = 3'b110;

    // One-hot instruction class; all-zero means the instruction is illegal
    typedef struct packed {
        logic add;
        logic sub;
        logic ori;
        logic lw;
        logic sw;
        logic beq;
        logic lui;
        logic jal;
        logic jr;
        logic j;
        logic bnezalc;
    } instr_class_t;

    // Larger of two integers, used to size the shared wait counter
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// mc_decode - combinational instruction classifier for mc_ctrl.
//
// Maps the opcode and function fields of the instruction register onto a
// one-hot instruction class and flags anything outside the supported set.
//
// Ports:
//   op       in   6  IR[31:26]
//   func     in   6  IR[5:0], only meaningful for R-type
//   cls      out     one-hot instruction class (mc_pkg::instr_class_t)
//   illegal  out  1  high when op/func is not a supported instruction

import mc_pkg::*;

module mc_decode (
    input  logic [5:0]   op,
    input  logic [5:0]   func,
    output instr_class_t cls,
    output logic         illegal
);

    // Classify the instruction; unknown op or an unknown R-type func leaves
    // every class bit clear, which is exactly the illegal condition.
    always_comb begin
        cls = '0;
        case (op)
            OP_RTYPE: begin
                case (func)
                    FUNC_ADD: cls.add = 1'b1;
                    FUNC_SUB: cls.sub = 1'b1;
                    FUNC_JR:  cls.jr  = 1'b1;
                    default:  ;
                endcase
            end
            OP_BNEZALC: cls.bnezalc = 1'b1;
            OP_J:       cls.j       = 1'b1;
            OP_JAL:     cls.jal     = 1'b1;
            OP_BEQ:     cls.beq     = 1'b1;
            OP_ORI:     cls.ori     = 1'b1;
            OP_LUI:     cls.lui     = 1'b1;
            OP_LW:      cls.lw      = 1'b1;
            OP_SW:      cls.sw      = 1'b1;
            default:    ;
        endcase
    end

    assign illegal = (cls == '0);

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl - multi-cycle controller for the MIPS datapath.
//
// Sequences each instruction through FETCH/DECODE/EXE/MEM/WB and drives the
// per-state control strobes as Mealy outputs of state, op, func and cmp_res.
// FETCH and MEM dwell for FETCH_LAT and MEM_LAT cycles respectively.
//
// Configuration macro: MC_ILLEGAL_TRAP_EN
//   defined   - an illegal instruction pulses 'illegal' and parks in HALT
//               until reset
//   undefined - an illegal instruction is retired as a NOP
//
// Ports:
//   clk         in   1  clock, rising edge
//   reset       in   1  asynchronous, active-high
//   op          in   6  IR[31:26]
//   func        in   6  IR[5:0]
//   cmp_res     in   1  comparator result for the current CMPop
//   PCwrite     out  1  PC load enable
//   IRwrite     out  1  instruction register load enable
//   RegDst      out  2  register destination select
//   Regwrite    out  1  GRF write enable
//   EXTop       out  1  immediate extension (1 = sign-extend)
//   ALUsrc      out  2  ALU B source select
//   ALUctrl     out  3  ALU operation
//   Memwrite    out  1  data-memory write enable
//   MemtoReg    out  2  writeback source select
//   NPCop       out  2  next-PC select
//   CMPop       out  3  comparator mode
//   state       out  3  current FSM state
//   instr_done  out  1  pulse on an instruction's last cycle
//   illegal     out  1  pulse when DECODE sees an unsupported op/func

import mc_pkg::*;

module mc_ctrl #(
    parameter int FETCH_LAT = 1,
    parameter int MEM_LAT   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       cmp_res,
    output logic       PCwrite,
    output logic       IRwrite,
    output logic [1:0] RegDst,
    output logic       Regwrite,
    output logic       EXTop,
    output logic [1:0] ALUsrc,
    output logic [2:0] ALUctrl,
    output logic       Memwrite,
    output logic [1:0] MemtoReg,
    output logic [1:0] NPCop,
    output logic [2:0] CMPop,
    output logic [2:0] state,
    output logic       instr_done,
    output logic       illegal
);

    // One counter serves both FETCH and MEM; it must reach the larger latency
    localparam int CW = $clog2(max_int(FETCH_LAT, MEM_LAT) + 1);
    localparam logic [CW-1:0] FETCH_LAST = CW'(FETCH_LAT - 1);
    localparam logic [CW-1:0] MEM_LAST   = CW'(MEM_LAT - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    instr_class_t  cls;
    logic          dec_illegal;

    logic       pcwrite_c, irwrite_c, regwrite_c, extop_c, memwrite_c;
    logic       done_c, illegal_c;
    logic [1:0] regdst_c, alusrc_c, memtoreg_c, npcop_c;
    logic [2:0] aluctrl_c, cmpop_c;

    mc_decode u_decode (
        .op      (op),
        .func    (func),
        .cls     (cls),
        .illegal (dec_illegal)
    );

    // State and wait-counter registers. An asynchronous reset returns to
    // FETCH immediately, abandoning any instruction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and Mealy output logic. The datapath selects depend only
    // on the instruction class and are driven in every state from DECODE
    // through WB so the datapath sees stable operands for the whole
    // instruction; write enables are gated by state below. The counter
    // defaults to zero so it clears on every state change, and only
    // increments while a dwelling state has not reached its last cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        pcwrite_c  = 1'b0;
        irwrite_c  = 1'b0;
        regwrite_c = 1'b0;
        memwrite_c = 1'b0;
        done_c     = 1'b0;
        illegal_c  = 1'b0;
        extop_c    = 1'b0;
        regdst_c   = REGDST_RT;
        alusrc_c   = ALUSRC_REG;
        aluctrl_c  = ALU_ADD;
        memtoreg_c = MEMTOREG_ALU;
        npcop_c    = NPC_PC4;
        cmpop_c    = CMP_EQ;

        if (state_q == ST_DECODE || state_q == ST_EXE ||
            state_q == ST_MEM    || state_q == ST_WB) begin
            if (cls.add) begin
                regdst_c  = REGDST_RD;
                aluctrl_c = ALU_ADD;
            end
            if (cls.sub) begin
                regdst_c  = REGDST_RD;
                aluctrl_c = ALU_SUB;
            end
            if (cls.ori) begin
                regdst_c  = REGDST_RT;
                alusrc_c  = ALUSRC_IMM;
                aluctrl_c = ALU_OR;
            end
            if (cls.lui) begin
                regdst_c   = REGDST_RT;
                memtoreg_c = MEMTOREG_LUI;
            end
            if (cls.lw || cls.sw) begin
                extop_c   = 1'b1;
                alusrc_c  = ALUSRC_IMM;
                aluctrl_c = ALU_ADD;
            end
            if (cls.lw) begin
                regdst_c   = REGDST_RT;
                memtoreg_c = MEMTOREG_DM;
            end
            if (cls.jal || cls.bnezalc) begin
                regdst_c   = REGDST_RA;
                memtoreg_c = MEMTOREG_PC;
            end
            if (cls.bnezalc) begin
                cmpop_c = CMP_NEZ;
            end
        end

        case (state_q)
            ST_FETCH: begin
                if (cnt_q == FETCH_LAST) begin
                    irwrite_c = 1'b1;
                    pcwrite_c = 1'b1;
                    npcop_c   = NPC_PC4;
                    state_d   = ST_DECODE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_DECODE: begin
                if (cls.j || cls.jal || cls.jr) begin
                    pcwrite_c  = 1'b1;
                    npcop_c    = cls.jr ? NPC_JR : NPC_J;
                    regwrite_c = cls.jal;
                    done_c     = 1'b1;
                    state_d    = ST_FETCH;
                end else if (cls.beq || cls.bnezalc) begin
                    // The link write for bnezalc only happens when taken
                    pcwrite_c  = cmp_res;
                    npcop_c    = NPC_BR;
                    regwrite_c = cls.bnezalc & cmp_res;
                    done_c     = 1'b1;
                    state_d    = ST_FETCH;
                end else if (dec_illegal) begin
                    illegal_c = 1'b1;
`ifdef MC_ILLEGAL_TRAP_EN
                    state_d   = ST_HALT;
`else
                    done_c    = 1'b1;
                    state_d   = ST_FETCH;
`endif
                end else begin
                    state_d = ST_EXE;
                end
            end

            ST_EXE: begin
                state_d = (cls.lw || cls.sw) ? ST_MEM : ST_WB;
            end

            ST_MEM: begin
                // A store writes once, on the first memory cycle only
                memwrite_c = cls.sw && (cnt_q == '0);
                if (cnt_q == MEM_LAST) begin
                    if (cls.sw) begin
                        done_c  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_WB: begin
                regwrite_c = 1'b1;
                done_c     = 1'b1;
                state_d    = ST_FETCH;
            end

            ST_HALT: begin
`ifdef MC_ILLEGAL_TRAP_EN
                state_d = ST_HALT;
`else
                state_d = ST_FETCH;
`endif
            end

            default: state_d = ST_FETCH;
        endcase
    end

    // Outputs are forced low while reset is held; without this FETCH would
    // present IRwrite/PCwrite on its final cycle even during reset.
    assign PCwrite    = pcwrite_c  & ~reset;
    assign IRwrite    = irwrite_c  & ~reset;
    assign Regwrite   = regwrite_c & ~reset;
    assign EXTop      = extop_c    & ~reset;
    assign Memwrite   = memwrite_c & ~reset;
    assign instr_done = done_c     & ~reset;
    assign illegal    = illegal_c  & ~reset;
    assign RegDst     = reset ? 2'b00  : regdst_c;
    assign ALUsrc     = reset ? 2'b00  : alusrc_c;
    assign ALUctrl    = reset ? 3'b000 : aluctrl_c;
    assign MemtoReg   = reset ? 2'b00  : memtoreg_c;
    assign NPCop      = reset ? 2'b00  : npcop_c;
    assign CMPop      = reset ? 3'b000 : cmpop_c;
    assign state      = state_q;

endmodule
